// File: rtl/pcie_consts.sv
// rtl/pcie_consts.sv - shared BRAM-side constants and request type for PCIe arbiters
package pcie_consts;
  localparam int BRAM_RD_LATENCY = 3;
  localparam int BRAM_ADDR_WIDTH = 16;
  localparam int BRAM_DATA_WIDTH = 512;

  typedef struct packed {
    logic                       wr;
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic [BRAM_DATA_WIDTH-1:0] wr_data;
  } bram_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant starting at rr_ptr
module rr_arbiter #(
  parameter int NB_REQ = 4
) (
  input  logic [NB_REQ-1:0]         valid,
  input  logic [$clog2(NB_REQ)-1:0] rr_ptr,
  output logic [NB_REQ-1:0]         grant,
  output logic [$clog2(NB_REQ)-1:0] grant_id,
  output logic                      grant_valid
);
  localparam int PTR_W = $clog2(NB_REQ);

  int               idx_i;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx_i       = 0;
    idx         = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      // Explicit modulo so non-power-of-two requester counts wrap correctly.
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NB_REQ) idx_i = idx_i - NB_REQ;
      idx = PTR_W'(idx_i);
      if (!grant_valid && valid[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end
endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin sharing of one BRAM port with in-order read tag pipeline
module bram_arbiter
  import pcie_consts::*;
#(
  parameter int NB_REQ     = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = BRAM_RD_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_REQ-1:0]            req_valid,
  output logic [NB_REQ-1:0]            req_ready,
  input  logic [NB_REQ-1:0]            req_wr,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic [NB_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]        bram_wr_data,
  output logic                         bram_rd_en,
  output logic                         bram_wr_en,
  input  logic [DATA_WIDTH-1:0]        bram_rd_data
);
  localparam int PTR_W = $clog2(NB_REQ);

  logic [NB_REQ-1:0]     arb_grant;
  logic [PTR_W-1:0]      arb_id;
  logic                  arb_valid;
  logic                  xfer;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]             bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]             bram_wr_data_q, bram_wr_data_d;
  logic                              bram_rd_en_q, bram_rd_en_d;
  logic                              bram_wr_en_q, bram_wr_en_d;
  logic [PTR_W-1:0]                  bram_id_q, bram_id_d;
  logic [RD_LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][PTR_W-1:0]  tag_id_q, tag_id_d;
  logic [NB_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]             rsp_data_q, rsp_data_d;

  rr_arbiter #(.NB_REQ(NB_REQ)) u_rr_arbiter (
    .valid       (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_id    (arb_id),
    .grant_valid (arb_valid)
  );

  // Grants are suppressed while reset is held so nothing is handshaken into a cleared pipeline.
  assign req_ready = rst_n ? arb_grant : '0;
  assign xfer      = rst_n & arb_valid;

  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_wr   = req_wr[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    bram_addr_d    = bram_addr_q;
    bram_wr_data_d = bram_wr_data_q;
    bram_rd_en_d   = 1'b0;
    bram_wr_en_d   = 1'b0;
    bram_id_d      = bram_id_q;
    if (xfer) begin
      rr_ptr_d    = (arb_id == PTR_W'(NB_REQ-1)) ? '0 : arb_id + 1'b1;
      bram_addr_d = sel_addr;
      bram_id_d   = arb_id;
      if (sel_wr) begin
        bram_wr_en_d   = 1'b1;
        bram_wr_data_d = sel_data;
      end else begin
        bram_rd_en_d = 1'b1;
      end
    end

    // Tag head follows the issued read, so the tail lines up with bram_rd_data.
    tag_vld_d[0] = bram_rd_en_q;
    tag_id_d[0]  = bram_id_q;
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[RD_LATENCY-1]) begin
      rsp_valid_d[tag_id_q[RD_LATENCY-1]] = 1'b1;
      rsp_data_d                          = bram_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      bram_addr_q    <= '0;
      bram_wr_data_q <= '0;
      bram_rd_en_q   <= 1'b0;
      bram_wr_en_q   <= 1'b0;
      bram_id_q      <= '0;
      tag_vld_q      <= '0;
      tag_id_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      bram_addr_q    <= bram_addr_d;
      bram_wr_data_q <= bram_wr_data_d;
      bram_rd_en_q   <= bram_rd_en_d;
      bram_wr_en_q   <= bram_wr_en_d;
      bram_id_q      <= bram_id_d;
      tag_vld_q      <= tag_vld_d;
      tag_id_q       <= tag_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign bram_addr    = bram_addr_q;
  assign bram_wr_data = bram_wr_data_q;
  assign bram_rd_en   = bram_rd_en_q;
  assign bram_wr_en   = bram_wr_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed and randomised checks of bram_arbiter against a BRAM and scoreboard model
module tb_bram_arbiter;
  localparam int NB = 4;
  localparam int AW = 16;
  localparam int DW = 512;

  logic            clk;
  logic            rst_n;
  logic [NB-1:0]   req_valid;
  logic [NB-1:0]   req_ready;
  logic [NB-1:0]   req_wr;
  logic [NB*AW-1:0] req_addr;
  logic [NB*DW-1:0] req_wr_data;
  logic [NB-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_wr_data;
  logic            bram_rd_en;
  logic            bram_wr_en;
  logic [DW-1:0]   bram_rd_data;

  int n_chk;
  int n_fail;

  bit [DW-1:0] bram_mem [256];
  bit [DW-1:0] exp_mem  [256];
  bit          v1, v2;
  bit [DW-1:0] d1, d2;
  logic [DW-1:0] sbq [NB][$];

  bram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_en   (bram_rd_en),
    .bram_wr_en   (bram_wr_en),
    .bram_rd_data (bram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM + mux: data appears three cycles after bram_rd_en and holds between reads.
  always @(posedge clk) begin
    if (bram_wr_en) bram_mem[bram_addr[7:0]] <= bram_wr_data;
    v1 <= bram_rd_en;
    d1 <= bram_mem[bram_addr[7:0]];
    v2 <= v1;
    d2 <= d1;
    if (v2) bram_rd_data <= d2;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'(32'h1111_1111 * (i + 1));
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic set_req(input int i, input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_wr[i]              = wr;
    req_addr[i*AW +: AW]   = a;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic sb_sample();
    logic [DW-1:0] e;
    logic [7:0]    a;
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (rsp_valid[i]) begin
          chk("rsp_expected", 512'(sbq[i].size() != 0), 512'(1));
          if (sbq[i].size() != 0) begin
            e = sbq[i].pop_front();
            chk("rsp_data_order", rsp_data, e);
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          a = req_addr[i*AW +: 8];
          if (req_wr[i]) exp_mem[a] = req_wr_data[i*DW +: DW];
          else sbq[i].push_back(exp_mem[a]);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] a5;
  logic [NB-1:0] eg;
  int            ref_ptr;

  initial begin
    n_chk = 0;
    n_fail = 0;
    a5 = {64{8'hA5}};
    rst_n = 1'b0;
    req_valid = '0;
    req_wr = '0;
    req_addr = '0;
    req_wr_data = '0;

    // Reset state, including grant suppression with every requester valid.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("ready_in_reset", 512'(req_ready), 512'(0));
    chk("ctrl_in_reset", 512'({rsp_valid, bram_rd_en, bram_wr_en, bram_addr}), 512'(0));
    chk("rsp_data_in_reset", rsp_data, '0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_ctrl", 512'({req_ready, rsp_valid, bram_rd_en, bram_wr_en, bram_addr}), 512'(0));
      chk("idle_wr_data", bram_wr_data, '0);
      chk("idle_rsp_data", rsp_data, '0);
      tick();
    end

    // Requester 2: write then read-back of the same address.
    set_req(2, 1'b1, 1'b1, 16'h0010, a5);
    #1;
    chk("wr_grant", 512'(req_ready), 512'(4'b0100));
    tick();
    req_wr[2] = 1'b0;
    #1;
    chk("rd_grant", 512'(req_ready), 512'(4'b0100));
    chk("wr_en", 512'({bram_wr_en, bram_rd_en}), 512'(2'b10));
    chk("wr_addr", 512'(bram_addr), 512'(16'h0010));
    chk("wr_data", bram_wr_data, a5);
    tick();
    req_valid = '0;
    #1;
    chk("rd_en", 512'({bram_wr_en, bram_rd_en}), 512'(2'b01));
    chk("rd_addr", 512'(bram_addr), 512'(16'h0010));
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk("rsp_latency_quiet", 512'(rsp_valid), 512'(0));
    end
    tick();
    #1;
    chk("raw_rsp_valid", 512'(rsp_valid), 512'(4'b0100));
    chk("raw_rsp_data", rsp_data, a5);

    // Write round with all valid; pointer sits at 3 after the read-back.
    tick();
    for (int i = 0; i < NB; i++) set_req(i, 1'b1, 1'b1, 16'(16'h0020 + i), pat(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wr_round_grant", 512'(req_ready), 512'(4'b0001 << ((3 + k) % 4)));
      tick();
    end

    // Eight back-to-back reads from all requesters, responses five cycles later.
    req_wr = '0;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk("rd_round_grant", 512'(req_ready), 512'(4'b0001 << (c % 4)));
      if (c >= 5) begin
        chk("rd_round_rsp_valid", 512'(rsp_valid), 512'(4'b0001 << ((c - 5) % 4)));
        chk("rd_round_rsp_data", rsp_data, pat((c - 5) % 4));
      end else begin
        chk("rd_round_rsp_quiet", 512'(rsp_valid), 512'(0));
      end
      tick();
    end

    // Move the pointer to 2, then contend between requesters 1 and 3.
    req_valid = 4'b0010;
    #1;
    chk("ptr_setup_grant", 512'(req_ready), 512'(4'b0010));
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pair_grant", 512'(req_ready), 512'((k % 2 == 0) ? 4'b1000 : 4'b0010));
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Three reads in flight, then reset for two cycles.
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pre_reset_grant", 512'(req_ready), 512'(4'b0001));
      tick();
    end
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_wr = 4'hF;
    #1;
    chk("mid_reset_ready", 512'(req_ready), 512'(0));
    chk("mid_reset_ctrl", 512'({rsp_valid, bram_rd_en, bram_wr_en}), 512'(0));
    tick();
    #1;
    chk("mid_reset_ready2", 512'(req_ready), 512'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset_grant", 512'(req_ready), 512'(4'b0001));
    chk("post_reset_rsp_quiet", 512'(rsp_valid), 512'(0));
    tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("discarded_rsp_quiet", 512'(rsp_valid), 512'(0));
      tick();
    end

    // Random mixed stream against the scoreboard and a round-robin reference.
    ref_ptr = 1;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NB; i++)
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), rand_word());
      eg = '0;
      for (int k = 0; k < NB; k++) begin
        if (eg == '0 && req_valid[(ref_ptr + k) % NB]) begin
          eg = 4'b0001 << ((ref_ptr + k) % NB);
          ref_ptr = (ref_ptr + k + 1) % NB;
        end
      end
      #1;
      chk("rand_grant", 512'(req_ready), 512'(eg));
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    for (int i = 0; i < NB; i++) chk("sb_drained", 512'(sbq[i].size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
